// File: rtl/dram_oq_defs.sv
// Shared definitions for the DRAM output-queue store and fetch stages.
package dram_oq_defs;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_REQ  = 4'b0010,
        ST_READ = 4'b0100,
        ST_DONE = 4'b1000
    } fetch_state_t;

    localparam int INIT_POS_DEF        = 0;
    localparam int DRAM_DATA_WIDTH_DEF = 144;
    localparam int DRAM_BLOCK_SIZE_DEF = 128;

    // A block holds DRAM_BLOCK_SIZE 64-bit words, packed two per DRAM word.
    function automatic int block_words(input int block_size);
        return block_size / 2;
    endfunction

endpackage

// File: rtl/oq_block_ptr.sv
// Wrapping block pointer for one DRAM queue; usable by both store and fetch sides.
module oq_block_ptr #(
    parameter int             W            = 3,
    parameter logic [W-1:0]   DEFAULT_ADDR = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] block_addr_hi,
    input  logic [W-1:0] block_addr_lo,
    input  logic         init,
    input  logic         advance,
    output logic [W-1:0] ptr,
    output logic [W-1:0] ptr_next
);

    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;

    assign ptr_next = (ptr >= hi_q) ? lo_q : ptr + W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            ptr  <= DEFAULT_ADDR;
        end else begin
            hi_q <= block_addr_hi;
            lo_q <= block_addr_lo;
            if (init)
                ptr <= lo_q;
            else if (advance)
                ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/fetch_pkt_dram.sv
// Reads whole DRAM blocks in FIFO order and pushes the words into the output-queue FIFO.
//   state   | meaning
//   ST_IDLE | wait for a filled block and FIFO room; apply queue init
//   ST_REQ  | hold dram_rd_req until the DRAM controller acks
//   ST_READ | forward each valid word to the FIFO one cycle later
//   ST_DONE | last write drains, pointer advances (or re-inits), block counted
module fetch_pkt_dram
    import dram_oq_defs::*;
#(
    parameter int DATA_WIDTH                 = 64,
    parameter int CTRL_WIDTH                 = DATA_WIDTH / 8,
    parameter int DRAM_ADDR_WIDTH            = 22,
    parameter int DRAM_DATA_WIDTH            = 2 * (DATA_WIDTH + CTRL_WIDTH),
    parameter int DRAM_BLOCK_RDWR_ADDR_WIDTH = 3,
    parameter int DRAM_BLOCK_SIZE            = DRAM_BLOCK_SIZE_DEF,
    parameter int OUT_FIFO_DEPTH             = 512,
    parameter int FIFO_MARGIN                = 8,
    parameter int DEFAULT_ADDR               = 0,
    parameter int INIT_POS                   = INIT_POS_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0] oq_wr_addr,
    output logic [DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0] oq_rd_addr,
    input  logic [DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0] block_addr_hi,
    input  logic [DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0] block_addr_lo,
    input  logic [1:0]                            ctrl,
    output logic                                  dram_rd_req,
    output logic [DRAM_ADDR_WIDTH-1:0]            dram_rd_ptr,
    input  logic                                  dram_rd_ack,
    input  logic [DRAM_DATA_WIDTH-1:0]            dram_rd_data,
    input  logic                                  dram_rd_data_vld,
    input  logic                                  dram_rd_done,
    output logic [DRAM_DATA_WIDTH-1:0]            fifo_din,
    output logic                                  fifo_wr_en,
    input  logic [$clog2(OUT_FIFO_DEPTH)-1:0]     fifo_wr_data_count,
    input  logic                                  fifo_full,
    output logic                                  fetch_idle,
    output logic                                  dram_rd_words,
    output logic                                  blocks_fetched,
    output logic                                  fetch_err
);

    localparam int BLK_W       = DRAM_BLOCK_RDWR_ADDR_WIDTH;
    localparam int CNT_W       = $clog2(OUT_FIFO_DEPTH);
    localparam int BLOCK_WORDS = block_words(DRAM_BLOCK_SIZE);
    localparam int WCNT_W      = $clog2(BLOCK_WORDS) + 2;
    localparam int BLK_SHIFT   = $clog2(DRAM_BLOCK_SIZE);
    localparam logic [CNT_W-1:0] ROOM_LIMIT =
        CNT_W'(OUT_FIFO_DEPTH - BLOCK_WORDS - FIFO_MARGIN);

    fetch_state_t             state, state_nxt;
    logic [BLK_W-1:0]         rd_next;
    logic                     ptr_init, ptr_adv;
    logic                     init_pend;
    logic                     init_req;
    logic                     data_avail, room_avail;
    logic [WCNT_W-1:0]        word_cnt;
    logic [DRAM_DATA_WIDTH-1:0] data_q;
    logic                     wr_en_q;
    logic                     err_q;
    logic                     flush_q;
    logic                     ctrl_unused;

    oq_block_ptr #(
        .W            (BLK_W),
        .DEFAULT_ADDR (BLK_W'(DEFAULT_ADDR))
    ) u_rd_ptr (
        .clk           (clk),
        .reset         (reset),
        .block_addr_hi (block_addr_hi),
        .block_addr_lo (block_addr_lo),
        .init          (ptr_init),
        .advance       (ptr_adv),
        .ptr           (oq_rd_addr),
        .ptr_next      (rd_next)
    );

    assign ctrl_unused   = ^ctrl;
    assign init_req      = init_pend | ctrl[INIT_POS];
    assign data_avail    = (oq_rd_addr != oq_wr_addr);
    assign room_avail    = (fifo_wr_data_count <= ROOM_LIMIT);
    assign dram_rd_ptr   = DRAM_ADDR_WIDTH'(oq_rd_addr) << BLK_SHIFT;
    assign dram_rd_words = dram_rd_data_vld && (state == ST_READ);
    assign fifo_din      = data_q;
    assign fifo_wr_en    = wr_en_q;
    assign fetch_idle    = (state == ST_IDLE) && !wr_en_q;
    assign fetch_err     = err_q;

    always_comb begin
        state_nxt      = state;
        dram_rd_req    = 1'b0;
        ptr_init       = 1'b0;
        ptr_adv        = 1'b0;
        blocks_fetched = 1'b0;
        case (state)
            ST_IDLE: begin
                if (init_req)
                    ptr_init = 1'b1;
                else if (data_avail && room_avail)
                    state_nxt = ST_REQ;
            end
            ST_REQ: begin
                dram_rd_req = 1'b1;
                if (dram_rd_ack)
                    state_nxt = ST_READ;
            end
            ST_READ: begin
                if (dram_rd_done)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                blocks_fetched = 1'b1;
                // A queue init requested during the block wins over the advance.
                if (init_req)
                    ptr_init = 1'b1;
                else
                    ptr_adv = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            init_pend <= 1'b0;
            word_cnt  <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            flush_q   <= 1'b1;
        end else begin
            state   <= state_nxt;
            wr_en_q <= dram_rd_words;
            if (dram_rd_words)
                data_q <= dram_rd_data;

            if (ptr_init)
                init_pend <= 1'b0;
            else if (ctrl[INIT_POS])
                init_pend <= 1'b1;

            if (state == ST_REQ && dram_rd_ack)
                word_cnt <= '0;
            else if (dram_rd_words)
                word_cnt <= word_cnt + WCNT_W'(1);

            // After reset, words of a block abandoned mid-read may still arrive;
            // they are dropped silently until that block's done or a new ack.
            if ((state == ST_REQ && dram_rd_ack) || dram_rd_done)
                flush_q <= 1'b0;

            if ((dram_rd_data_vld && state != ST_READ && !flush_q) ||
                (wr_en_q && fifo_full) ||
                (state == ST_DONE && word_cnt != WCNT_W'(BLOCK_WORDS)))
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_pkt_dram.sv
// Directed bench for fetch_pkt_dram: block reads, wrap, FIFO room, init, errors, reset.
module tb_fetch_pkt_dram;
    import dram_oq_defs::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   oq_wr_addr, oq_rd_addr, block_addr_hi, block_addr_lo;
    logic [1:0]   ctrl;
    logic         dram_rd_req, dram_rd_ack, dram_rd_data_vld, dram_rd_done;
    logic [21:0]  dram_rd_ptr;
    logic [DRAM_DATA_WIDTH_DEF-1:0] dram_rd_data, fifo_din;
    logic         fifo_wr_en, fifo_full;
    logic [8:0]   fifo_wr_data_count;
    logic         fetch_idle, dram_rd_words, blocks_fetched, fetch_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pkt_dram dut (
        .clk                (clk),
        .reset              (reset),
        .oq_wr_addr         (oq_wr_addr),
        .oq_rd_addr         (oq_rd_addr),
        .block_addr_hi      (block_addr_hi),
        .block_addr_lo      (block_addr_lo),
        .ctrl               (ctrl),
        .dram_rd_req        (dram_rd_req),
        .dram_rd_ptr        (dram_rd_ptr),
        .dram_rd_ack        (dram_rd_ack),
        .dram_rd_data       (dram_rd_data),
        .dram_rd_data_vld   (dram_rd_data_vld),
        .dram_rd_done       (dram_rd_done),
        .fifo_din           (fifo_din),
        .fifo_wr_en         (fifo_wr_en),
        .fifo_wr_data_count (fifo_wr_data_count),
        .fifo_full          (fifo_full),
        .fetch_idle         (fetch_idle),
        .dram_rd_words      (dram_rd_words),
        .blocks_fetched     (blocks_fetched),
        .fetch_err          (fetch_err)
    );

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [143:0] pat(input int blk, input int idx);
        logic [143:0] v;
        v = {9{16'(idx) ^ 16'h5a3c}};
        v[143:128] = 16'(blk);
        return v;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (dram_rd_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("req_timeout", 0, 1);
    endtask

    task automatic send_words(input int first, input int last, input int blk,
                              input int init_at, input bit expect_wr);
        for (int i = first; i <= last; i++) begin
            dram_rd_data_vld = 1'b1;
            dram_rd_data     = pat(blk, i);
            dram_rd_done     = (i == 63) || (i == last && expect_wr);
            ctrl             = (i == init_at) ? 2'b01 : 2'b00;
            #1;
            check("rd_words", dram_rd_words, expect_wr);
            step();
            check("wr_en", fifo_wr_en, expect_wr);
            if (expect_wr) begin
                check("din", fifo_din, pat(blk, i));
                check("idle_busy", fetch_idle, 0);
            end
        end
        dram_rd_data_vld = 1'b0;
        dram_rd_done     = 1'b0;
        ctrl             = 2'b00;
    endtask

    task automatic run_block(input int nwords, input int exp_ptr, input int init_at,
                             input int exp_rd, input bit exp_err);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        check("rd_ptr", dram_rd_ptr, exp_ptr);
        check("idle_in_req", fetch_idle, 0);
        dram_rd_ack = 1'b1;
        step();
        dram_rd_ack = 1'b0;
        check("req_drop", dram_rd_req, 0);
        check("wr_en_pre", fifo_wr_en, 0);
        send_words(0, nwords - 1, exp_ptr, init_at, 1'b1);
        check("blk_pulse", blocks_fetched, 1);
        step();
        check("blk_pulse_end", blocks_fetched, 0);
        check("wr_en_end", fifo_wr_en, 0);
        check("idle_back", fetch_idle, 1);
        check("rd_addr", oq_rd_addr, exp_rd);
        check("err", fetch_err, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        bit ok;
        reset = 1'b1;
        oq_wr_addr = 3'd0; block_addr_hi = 3'd3; block_addr_lo = 3'd0;
        ctrl = 2'b00; dram_rd_ack = 1'b0; dram_rd_data = '0;
        dram_rd_data_vld = 1'b0; dram_rd_done = 1'b0;
        fifo_wr_data_count = 9'd0; fifo_full = 1'b0;
        repeat (3) step();
        check("rst_rd_addr", oq_rd_addr, 0);
        check("rst_idle", fetch_idle, 1);
        check("rst_req", dram_rd_req, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_err", fetch_err, 0);
        check("rst_blk", blocks_fetched, 0);
        check("rst_words", dram_rd_words, 0);
        reset = 1'b0;
        repeat (4) step();
        check("no_req_empty", dram_rd_req, 0);

        // Basic block, then nothing left to read.
        oq_wr_addr = 3'd1;
        run_block(64, 0, -1, 1, 1'b0);
        repeat (3) step();
        check("no_req_after", dram_rd_req, 0);

        // Walk to the top block and wrap back to lo.
        oq_wr_addr = 3'd3;
        run_block(64, 128, -1, 2, 1'b0);
        run_block(64, 256, -1, 3, 1'b0);
        oq_wr_addr = 3'd0;
        run_block(64, 384, -1, 0, 1'b0);
        repeat (3) step();
        check("no_req_wrap", dram_rd_req, 0);

        // FIFO room threshold.
        fifo_wr_data_count = 9'd441;
        oq_wr_addr = 3'd1;
        repeat (5) step();
        check("no_req_441", dram_rd_req, 0);
        fifo_wr_data_count = 9'd440;
        step();
        check("req_at_440", dram_rd_req, 1);
        run_block(64, 0, -1, 1, 1'b0);
        fifo_wr_data_count = 9'd0;

        // Init mid-read: rd goes to lo=2 rather than advancing to 3.
        oq_wr_addr = 3'd2;
        run_block(64, 128, -1, 2, 1'b0);
        block_addr_lo = 3'd2;
        oq_wr_addr = 3'd0;
        run_block(64, 256, 10, 2, 1'b0);
        oq_wr_addr = 3'd2;
        step();
        check("no_req_init", dram_rd_req, 0);

        // Short block flags an error; the following block still runs.
        oq_wr_addr = 3'd3;
        run_block(63, 256, -1, 3, 1'b1);
        oq_wr_addr = 3'd0;
        run_block(64, 384, -1, 2, 1'b1);
        oq_wr_addr = 3'd2;

        // Reset in the middle of a block.
        reset = 1'b1; step(); step(); reset = 1'b0;
        oq_wr_addr = 3'd3;
        repeat (2) step();
        wait_req(ok);
        if (ok) begin
            check("rst_blk_ptr", dram_rd_ptr, 0);
            dram_rd_ack = 1'b1; step(); dram_rd_ack = 1'b0;
            send_words(0, 29, 0, -1, 1'b1);
            reset = 1'b1;
            oq_wr_addr = 3'd0;
            block_addr_lo = 3'd0;
            dram_rd_data_vld = 1'b1;
            dram_rd_data = pat(0, 30);
            step();
            check("mid_rst_rd", oq_rd_addr, 0);
            check("mid_rst_req", dram_rd_req, 0);
            check("mid_rst_wr_en", fifo_wr_en, 0);
            check("mid_rst_words", dram_rd_words, 0);
            check("mid_rst_blk", blocks_fetched, 0);
            check("mid_rst_err", fetch_err, 0);
            check("mid_rst_idle", fetch_idle, 1);
            reset = 1'b0;
            send_words(31, 63, 0, -1, 1'b0);
            step();
            check("stale_err", fetch_err, 0);
            check("stale_req", dram_rd_req, 0);
            check("stale_blk", blocks_fetched, 0);
        end

        // A word arriving outside a read is an error.
        dram_rd_data_vld = 1'b1;
        step();
        dram_rd_data_vld = 1'b0;
        check("stray_err", fetch_err, 1);

        // Writing while the FIFO reports full is an error, but the block completes.
        reset = 1'b1; step(); step(); reset = 1'b0;
        check("err_cleared", fetch_err, 0);
        oq_wr_addr = 3'd1;
        fifo_full = 1'b1;
        run_block(64, 0, -1, 1, 1'b1);
        fifo_full = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pkt_dram.md
Name: fetch_pkt_dram

Overview:
- Downstream read stage of the DRAM output queue; the store side fills DRAM blocks and advances its block write pointer.
- This block reads whole DRAM blocks back in FIFO order and pushes the 144-bit words into the output-queue FIFO feeding the packet remover.
- Owns the block read pointer (oq_rd_addr) that the store side uses for its full check and shortcut decision.
- Raises fetch_idle so the store side's shortcut path and this block never write the output FIFO in the same cycle.

Parameters:
- DATA_WIDTH, 64, packet data word width.
- CTRL_WIDTH, DATA_WIDTH/8, packet control width.
- DRAM_ADDR_WIDTH, 22, DRAM word address width.
- DRAM_DATA_WIDTH, 2*(DATA_WIDTH+CTRL_WIDTH) = 144, DRAM/output FIFO word width.
- DRAM_BLOCK_RDWR_ADDR_WIDTH, 3, block index width.
- DRAM_BLOCK_SIZE, 128, block size in 64-bit words (64 DRAM words per block).
- OUT_FIFO_DEPTH, 512, output FIFO depth in 144-bit words.
- FIFO_MARGIN, 8, extra free slots required beyond one block before a request.
- DEFAULT_ADDR, 0, oq_rd_addr value at reset.
- INIT_POS, 0, bit of ctrl meaning "initialize queue".

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- oq_wr_addr  in  BLK_W  store-side block write pointer.
- oq_rd_addr  out  BLK_W  block read pointer.
- block_addr_hi  in  BLK_W  highest block index of this queue.
- block_addr_lo  in  BLK_W  lowest block index of this queue.
- ctrl  in  2  queue control; bit INIT_POS = initialize.
- dram_rd_req  out  1  read request.
- dram_rd_ptr  out  DRAM_ADDR_WIDTH  block start address, oq_rd_addr*DRAM_BLOCK_SIZE.
- dram_rd_ack  in  1  request accepted.
- dram_rd_data  in  144  read data.
- dram_rd_data_vld  in  1  read data valid.
- dram_rd_done  in  1  last word of the block has been delivered.
- fifo_din  out  144  output FIFO write data.
- fifo_wr_en  out  1  output FIFO write enable.
- fifo_wr_data_count  in  9  output FIFO occupancy.
- fifo_full  in  1  output FIFO full.
- fetch_idle  out  1  high only in ST_IDLE with no write pending.
- dram_rd_words  out  1  pulse per word accepted.
- blocks_fetched  out  1  pulse per completed block.
- fetch_err  out  1  sticky: word count mismatch or write while full.

Behaviour:
- Reset values: state ST_IDLE, oq_rd_addr=DEFAULT_ADDR, fetch_idle=1, fetch_err=0, pending init=0, word count=0. All request, enable and pulse outputs are 0.
- hi/lo pass through one register stage, as on the store side. Wrap rule: next = (rd >= hi_q) ? lo_q : rd+1.
- Data available when oq_rd_addr != oq_wr_addr.
- Room available when fifo_wr_data_count <= OUT_FIFO_DEPTH - DRAM_BLOCK_SIZE/2 - FIFO_MARGIN, i.e. <= 440 at defaults.
- ST_IDLE:
  - If init is pending or ctrl[INIT_POS] is set: oq_rd_addr <= lo_q, clear pending, stay in ST_IDLE.
  - Otherwise, if data available and room available -> ST_REQ.
- ST_REQ: dram_rd_req=1 and dram_rd_ptr held stable. On dram_rd_ack -> ST_READ with word count cleared.
- ST_READ:
  - Each dram_rd_data_vld: register the data; fifo_din/fifo_wr_en assert exactly 1 cycle later; dram_rd_words pulses in the vld cycle; word count increments.
  - dram_rd_done (may coincide with the last vld) -> ST_DONE.
- ST_DONE (1 cycle): the last registered write drains; oq_rd_addr <= next; blocks_fetched=1.
  - If the final count != DRAM_BLOCK_SIZE/2, set fetch_err.
  - Then -> ST_IDLE.
- ctrl[INIT_POS] outside ST_IDLE latches pending init. The block is never abandoned mid-read; init applies on return to ST_IDLE, overriding that cycle's advance.
- fifo_wr_en while fifo_full sets fetch_err. The write is still issued; the block does not stall DRAM.
- fetch_idle=0 from ST_REQ until the cycle after the final fifo write.
- Reset mid-read: everything returns to reset values and in-flight DRAM data is ignored.
- dram_rd_data_vld outside ST_READ is ignored and sets fetch_err.

Decomposition:
- Shared package (dram_oq_defs): state encodings (one-hot, 4 bits), INIT_POS, DRAM_DATA_WIDTH, and the block-words constant (DRAM_BLOCK_SIZE/2).
- One natural sub-module: oq_block_ptr, the wrapping block pointer (hi/lo registers, advance, init). It is reusable by the store side.

Test Plan:
- lo=0, hi=3, wr=1, fifo count 0 -> one request with dram_rd_ptr=0. 64 vld words give 64 fifo writes, each 1 cycle later. Then rd_addr=1, blocks_fetched pulses once, fetch_idle returns to 1.
- rd=3, hi=3, lo=0, wr=0 -> after the block, rd_addr wraps to 0 and no further request is made.
- fifo_wr_data_count=441 with data available -> no request. Dropping the count to 440 gives dram_rd_req the next cycle.
- ctrl[0] pulsed mid-READ with lo=2 -> the block completes, then rd_addr=2 (not the incremented value) and no error.
- dram_rd_done after 63 words -> fetch_err=1, stays set until reset. The next block still proceeds.
- Reset asserted at word 30 -> next cycle: rd_addr=DEFAULT_ADDR, all outputs 0, fetch_idle=1. The remaining vld pulses are ignored without error.
